// File: rtl/demux_channel_collector.sv
// demux_channel_collector: deserialises four demux lanes into words and
// presents them round-robin on one valid/ready port tagged with the channel
module demux_channel_collector #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_valid,
   input  logic [1:0]       ch_sel,
   input  logic [3:0]       ch_bits,
   input  logic             resync,
   input  logic             clr_ovf,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_chan,
   output logic [3:0]       overflow
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] sh [4];
   logic [CW-1:0]    cnt [4];
   logic [WIDTH-1:0] slot [4];
   logic [3:0]       pend;
   logic [1:0]       ptr, gnt, idx;
   logic             gnt_v, bit_in, done, load;
   logic [WIDTH-1:0] word;

   assign bit_in = ch_bits[ch_sel];
   assign word   = {sh[ch_sel][WIDTH-2:0], bit_in};
   assign done   = bit_valid && !resync && cnt[ch_sel] == CW'(WIDTH - 1);
   assign load   = !out_valid || out_ready;

   // first pending slot after the last granted channel
   always_comb begin
      gnt_v = 1'b0;
      gnt   = ptr;
      idx   = ptr;
      for (int i = 1; i <= 4; i++) begin
         idx = ptr + 2'(i);
         if (!gnt_v && pend[idx]) begin
            gnt_v = 1'b1;
            gnt   = idx;
         end
      end
   end

   // MSB-first shift registers and bit counters, cleared by resync
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || resync) begin
         for (int c = 0; c < 4; c++) begin
            sh[c]  <= '0;
            cnt[c] <= '0;
         end
      end else if (bit_valid) begin
         sh[ch_sel]  <= word;
         cnt[ch_sel] <= done ? '0 : cnt[ch_sel] + CW'(1);
      end
   end

   // pending slots accept a finished word if empty or draining this edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= '0;
         overflow <= '0;
         for (int c = 0; c < 4; c++) slot[c] <= '0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (clr_ovf) overflow[c] <= 1'b0;
            if (done && ch_sel == 2'(c)) begin
               if (!pend[c] || (load && gnt_v && gnt == 2'(c))) begin
                  slot[c] <= word;
                  pend[c] <= 1'b1;
               end else begin
                  overflow[c] <= 1'b1;
               end
            end else if (load && gnt_v && gnt == 2'(c)) begin
               pend[c] <= 1'b0;
            end
         end
      end
   end

   // output register refills whenever empty or being accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= 2'd3;
      end else if (load) begin
         out_valid <= gnt_v;
         if (gnt_v) begin
            out_data <= slot[gnt];
            out_chan <= gnt;
            ptr      <= gnt;
         end
      end
   end
endmodule

// File: tb/tb_demux_channel_collector.sv
// tb_demux_channel_collector: directed and random checks against a word-level model
module tb_demux_channel_collector;
   localparam int W = 8;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         bit_valid = 1'b0, resync = 1'b0, clr_ovf = 1'b0, out_ready = 1'b0;
   logic [1:0]   ch_sel = '0;
   logic [3:0]   ch_bits = '0;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_chan;
   logic [3:0]   overflow;

   int passed = 0, fails = 0, total = 0;
   int m_acc[4], m_n[4], m_slot[4];
   bit m_pend[4];
   int m_ov, m_v, m_d, m_c, m_ptr;
   int w4[4] = '{'h81, 'h42, 'h24, 'h18};

   demux_channel_collector #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .ch_sel(ch_sel),
      .ch_bits(ch_bits), .resync(resync), .clr_ovf(clr_ovf), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int c = 0; c < 4; c++) begin
         m_acc[c] = 0; m_n[c] = 0; m_slot[c] = 0; m_pend[c] = 0;
      end
      m_ov = 0; m_v = 0; m_d = 0; m_c = 0; m_ptr = 3;
   endfunction

   // one clock edge of the word-level model, using the inputs at that edge
   function automatic void m_edge();
      int g = -1, fin = -1, wd = 0, ovs = 0;
      bit load = (m_v == 0) || out_ready;
      for (int k = 1; k <= 4; k++)
         if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      if (resync) begin
         for (int c = 0; c < 4; c++) begin m_acc[c] = 0; m_n[c] = 0; end
      end else if (bit_valid) begin
         m_acc[ch_sel] = (m_acc[ch_sel] * 2 + int'(ch_bits[ch_sel])) % (1 << W);
         m_n[ch_sel]++;
         if (m_n[ch_sel] == W) begin
            m_n[ch_sel] = 0; fin = ch_sel; wd = m_acc[ch_sel];
         end
      end
      if (load) begin
         if (g >= 0) begin
            m_v = 1; m_d = m_slot[g]; m_c = g; m_ptr = g; m_pend[g] = 0;
         end else m_v = 0;
      end
      if (fin >= 0) begin
         if (!m_pend[fin]) begin m_slot[fin] = wd; m_pend[fin] = 1; end
         else ovs = 1 << fin;
      end
      m_ov = (clr_ovf ? 0 : m_ov) | ovs;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, out_valid, m_v);
      chk({tag, ".data"}, out_data, m_d);
      chk({tag, ".chan"}, out_chan, m_c);
      chk({tag, ".ovf"}, overflow, m_ov);
   endtask

   task automatic step(input bit bv, input int sel, input logic [3:0] bits,
                       input bit rs, input bit clr, input bit rdy);
      bit_valid = bv; ch_sel = 2'(sel); ch_bits = bits;
      resync = rs; clr_ovf = clr; out_ready = rdy;
      @(posedge clk);
      m_edge();
      #1;
      check_all("cyc");
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 4'h0, 0, 0, rdy);
   endtask

   task automatic send_bit(input int ch, input int b, input bit rdy, input logic [3:0] noise);
      logic [3:0] bits;
      bits = noise;
      bits[ch] = b[0];
      step(1, ch, bits, 0, 0, rdy);
   endtask

   task automatic send_word(input int ch, input int word, input bit rdy, input logic [3:0] noise);
      for (int i = W - 1; i >= 0; i--) send_bit(ch, (word >> i) & 1, rdy, noise);
   endtask

   initial begin
      m_reset();
      #12;
      check_all("reset");
      rst_n = 1'b1;

      send_word(2, 'hB2, 1, 4'h0);
      chk("t1_early", out_valid, 0);
      idle(1);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 'hB2);
      chk("t1_chan", out_chan, 2);
      idle(1);
      chk("t1_pulse", out_valid, 0);

      for (int r = 0; r < 2; r++) begin
         for (int i = W - 1; i >= 0; i--)
            for (int c = 0; c < 4; c++) send_bit(c, (w4[c] >> i) & 1, 0, 4'h0);
         chk("t2_first_chan", out_chan, 0);
         chk("t2_first_data", out_data, w4[0]);
         for (int k = 1; k < 4; k++) begin
            idle(1);
            chk("t2_chan", out_chan, k);
            chk("t2_data", out_data, w4[k]);
         end
         idle(1);
         chk("t2_drain", out_valid, 0);
      end

      send_word(1, 'hA1, 0, 4'h0);
      send_word(1, 'h5E, 0, 4'h0);
      send_word(1, 'hC3, 0, 4'h0);
      chk("t3_ovf", overflow, 4'b0010);
      chk("t3_hold", out_data, 'hA1);
      idle(1);
      chk("t3_second", out_data, 'h5E);
      chk("t3_chan", out_chan, 1);
      idle(1);
      chk("t3_empty", out_valid, 0);
      step(0, 0, 4'h0, 0, 1, 1);
      chk("t3_clr", overflow, 0);

      for (int i = 0; i < 5; i++) send_bit(0, 1, 1, 4'h0);
      step(1, 0, 4'h1, 1, 0, 1);
      send_word(0, 'h5A, 1, 4'h0);
      idle(1);
      chk("t4_data", out_data, 'h5A);
      chk("t4_chan", out_chan, 0);
      idle(1);

      send_word(1, 'h77, 0, 4'h0);
      send_word(3, 'hAA, 0, 4'h0);
      for (int i = W - 1; i >= 1; i--) send_bit(3, ('h55 >> i) & 1, 0, 4'h0);
      send_bit(3, 1, 1, 4'h0);
      chk("t5_ovf", overflow, 0);
      chk("t5_first", out_data, 'hAA);
      idle(1);
      chk("t5_second", out_data, 'h55);
      chk("t5_chan", out_chan, 3);
      idle(1);

      send_word(0, 'h00, 0, 4'b1110);
      send_word(2, 'hC5, 0, 4'h0);
      chk("t6_noise", out_data, 'h00);
      chk("t6_busy", out_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      m_reset();
      chk("t6_async", out_valid, 0);
      check_all("t6_rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) idle(1);
      chk("t6_nostale", out_valid, 0);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 4'($urandom),
              $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 2) != 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
